psg_pan_mixer: RTL and testbench



---
 rtl/psg_mix_pkg.sv | 28 ++
 rtl/psg_lpf.sv | 50 +++++
 rtl/psg_pan_mixer.sv | 157 +++++++++++++++
 tb/tb_psg_pan_mixer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/psg_mix_pkg.sv
// rtl/psg_mix_pkg.sv - shared types and constants for the PSG stereo pan mixer
package psg_mix_pkg;

    typedef enum logic [1:0] {
        MONO = 2'd0,
        ABC  = 2'd1,
        ACB  = 2'd2,
        PAN  = 2'd3
    } mix_mode_t;

    localparam logic [1:0] PAN_BOTH  = 2'b00;
    localparam logic [1:0] PAN_LEFT  = 2'b01;
    localparam logic [1:0] PAN_RIGHT = 2'b10;
    localparam logic [1:0] PAN_MUTE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } mix_state_t;

    // Accumulator width: wide enough that summing every channel never overflows.
    function automatic int calc_accw(input int iw, input int nch);
        return iw + $clog2(nch);
    endfunction

endpackage

// File: rtl/psg_lpf.sv
// rtl/psg_lpf.sv - scaler plus optional one-pole low-pass filter for one output side
module psg_lpf #(
    parameter int ACCW      = 14,
    parameter int OW        = 16,
    parameter int LPF_SHIFT = 3
) (
    input  logic            clk_sys,
    input  logic            RESET,
    input  logic            i_update,
    input  logic            i_lpf_en,
    input  logic [ACCW-1:0] i_acc,
    output logic [OW-1:0]   o_y
);

    logic [OW-1:0]        w_x;
    logic [OW-1:0]        w_y_filt;
    logic [OW-1:0]        w_y;
    logic [OW-1:0]        r_y_prev;
    logic signed [OW+1:0] w_diff;
    logic signed [OW+1:0] w_step;

    // Bring the accumulator to the output width: left-justify when narrower, drop LSBs when wider.
    generate
        if (ACCW <= OW) begin : g_scale_up
            assign w_x = OW'(i_acc) << (OW - ACCW);
        end else begin : g_scale_down
            assign w_x = i_acc[ACCW-1 -: OW];
        end
    endgenerate

    // y = y_prev + ((x - y_prev) >>> LPF_SHIFT); two guard bits keep the difference signed and exact.
    always_comb begin
        w_diff   = $signed({2'b00, w_x}) - $signed({2'b00, r_y_prev});
        w_step   = w_diff >>> LPF_SHIFT;
        w_y_filt = OW'($signed({2'b00, r_y_prev}) + w_step);
        w_y      = i_lpf_en ? w_y_filt : w_x;
    end

    // Filter memory follows the delivered output every sample, so enabling the filter starts from the current level.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_y_prev <= '0;
            o_y      <= '0;
        end else if (i_update) begin
            r_y_prev <= w_y;
            o_y      <= w_y;
        end
    end

endmodule

// File: rtl/psg_pan_mixer.sv
// rtl/psg_pan_mixer.sv - serial N-channel PSG stereo mixer with mode/pan routing and optional LPF
import psg_mix_pkg::*;

module psg_pan_mixer #(
    parameter int NCH       = 3,
    parameter int IW        = 12,
    parameter int OW        = 16,
    parameter int LPF_SHIFT = 3
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              ce_sample,
    input  logic [NCH*IW-1:0] ch_in,
    input  logic [1:0]        mode,
    input  logic [2*NCH-1:0]  pan,
    input  logic              lpf_en,
    output logic [OW-1:0]     out_l,
    output logic [OW-1:0]     out_r,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int ACCW = calc_accw(IW, NCH);
    localparam int IDXW = $clog2(NCH);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCH - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    mix_state_t        r_state;
    mix_state_t        w_next;
    logic [NCH*IW-1:0] r_ch;
    mix_mode_t         r_mode;
    logic [2*NCH-1:0]  r_pan;
    logic              r_lpf_en;
    logic [IDXW-1:0]   r_idx;
    logic [ACCW-1:0]   r_acc_l;
    logic [ACCW-1:0]   r_acc_r;
    logic              r_overrun;
    logic              w_capture;
    logic              w_acc_en;
    logic              w_update;
    logic              w_to_l;
    logic              w_to_r;
    logic [1:0]        w_pan_code;
    logic [IW-1:0]     w_ch;

    // State register
    always_ff @(posedge clk_sys) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state: one ACC cycle per channel, then SCALE and a single OUT cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (ce_sample) w_next = ACC;
            ACC:     if (r_idx == IDX_LAST) w_next = SCALE;
            SCALE:   w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State-decoded controls and status outputs
    always_comb begin
        w_capture = (r_state == IDLE) && ce_sample;
        w_acc_en  = (r_state == ACC);
        w_update  = (r_state == SCALE);
        busy      = (r_state != IDLE);
        out_valid = (r_state == OUT);
    end

    assign w_ch       = r_ch[r_idx*IW +: IW];
    assign w_pan_code = r_pan[2*r_idx +: 2];

    // Routing decode for the channel currently being summed
    always_comb begin
        w_to_l = 1'b1;
        w_to_r = 1'b1;
        case (r_mode)
            ABC: begin
                if (r_idx == '0)           w_to_r = 1'b0;
                else if (r_idx == IDX_LAST) w_to_l = 1'b0;
            end
            ACB: begin
                if (r_idx == '0)           w_to_r = 1'b0;
                else if (r_idx == IDX_ONE) w_to_l = 1'b0;
            end
            PAN: begin
                w_to_l = (w_pan_code == PAN_BOTH) || (w_pan_code == PAN_LEFT);
                w_to_r = (w_pan_code == PAN_BOTH) || (w_pan_code == PAN_RIGHT);
            end
            default: ;
        endcase
    end

    // Capture the sample set on the strobe, then accumulate one channel per cycle
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_ch     <= '0;
            r_mode   <= MONO;
            r_pan    <= '0;
            r_lpf_en <= 1'b0;
            r_idx    <= '0;
            r_acc_l  <= '0;
            r_acc_r  <= '0;
        end else if (w_capture) begin
            r_ch     <= ch_in;
            r_mode   <= mix_mode_t'(mode);
            r_pan    <= pan;
            r_lpf_en <= lpf_en;
            r_idx    <= '0;
            r_acc_l  <= '0;
            r_acc_r  <= '0;
        end else if (w_acc_en) begin
            if (w_to_l) r_acc_l <= r_acc_l + ACCW'(w_ch);
            if (w_to_r) r_acc_r <= r_acc_r + ACCW'(w_ch);
            if (r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
        end
    end

    // Sticky flag for strobes that land while a mix is still running
    always_ff @(posedge clk_sys) begin
        if (RESET)                               r_overrun <= 1'b0;
        else if (ce_sample && r_state != IDLE) r_overrun <= 1'b1;
    end

    assign overrun = r_overrun;

    psg_lpf #(
        .ACCW      (ACCW),
        .OW        (OW),
        .LPF_SHIFT (LPF_SHIFT)
    ) u_lpf_l (
        .clk_sys  (clk_sys),
        .RESET    (RESET),
        .i_update (w_update),
        .i_lpf_en (r_lpf_en),
        .i_acc    (r_acc_l),
        .o_y      (out_l)
    );

    psg_lpf #(
        .ACCW      (ACCW),
        .OW        (OW),
        .LPF_SHIFT (LPF_SHIFT)
    ) u_lpf_r (
        .clk_sys  (clk_sys),
        .RESET    (RESET),
        .i_update (w_update),
        .i_lpf_en (r_lpf_en),
        .i_acc    (r_acc_r),
        .o_y      (out_r)
    );

endmodule

// File: tb/tb_psg_pan_mixer.sv
// tb/tb_psg_pan_mixer.sv - scoreboard bench for psg_pan_mixer with directed vectors
module tb_psg_pan_mixer;

    localparam int NCH = 3;
    localparam int IW  = 12;
    localparam int OW  = 16;

    logic              clk_sys = 1'b0;
    logic              RESET;
    logic              ce_sample;
    logic [NCH*IW-1:0] ch_in;
    logic [1:0]        mode;
    logic [2*NCH-1:0]  pan;
    logic              lpf_en;
    logic [OW-1:0]     out_l;
    logic [OW-1:0]     out_r;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    typedef struct {
        int l;
        int r;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    psg_pan_mixer #(
        .NCH       (NCH),
        .IW        (IW),
        .OW        (OW),
        .LPF_SHIFT (3)
    ) dut (
        .clk_sys   (clk_sys),
        .RESET     (RESET),
        .ce_sample (ce_sample),
        .ch_in     (ch_in),
        .mode      (mode),
        .pan       (pan),
        .lpf_en    (lpf_en),
        .out_l     (out_l),
        .out_r     (out_r),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int l, input int r, input int c);
        exp_t e;
        e.l   = l;
        e.r   = r;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic set_ch(input int a, input int b, input int c);
        ch_in = {IW'(c), IW'(b), IW'(a)};
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic issue_now(output int t);
        ce_sample = 1'b1;
        t = cyc;
        @(posedge clk_sys);
        #1;
        ce_sample = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk_sys);
            #1;
            k++;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    // Monitor: every out_valid pulse must match the oldest expected result, including its cycle
    always @(negedge clk_sys) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got l=%0d r=%0d at cycle %0d, expected no pulse", out_l, out_r, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_l", int'(out_l), e.l);
                check("out_r", int'(out_r), e.r);
                check("valid_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int t2;
        RESET     = 1'b1;
        ce_sample = 1'b0;
        ch_in     = '0;
        mode      = 2'd0;
        pan       = '0;
        lpf_en    = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        RESET = 1'b0;

        check("rst_out_l", int'(out_l), 0);
        check("rst_out_r", int'(out_r), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);

        // Mono full scale: 3*4095 << 2
        mode = 2'd0;
        set_ch(4095, 4095, 4095);
        issue_now(t);
        push_exp(49140, 49140, t + 5);
        check("busy_T1", int'(busy), 1);
        wait_to(t + 4);
        check("valid_T4", int'(out_valid), 0);
        wait_to(t + 5);
        check("busy_T5", int'(busy), 1);
        wait_to(t + 6);
        check("busy_T6", int'(busy), 0);
        check("valid_T6", int'(out_valid), 0);

        // ABC, strobed at exactly the minimum spacing
        mode = 2'd1;
        set_ch(100, 200, 300);
        issue_now(t);
        push_exp(1200, 2000, t + 5);
        wait_to(t + 6);

        // ACB
        mode = 2'd2;
        issue_now(t);
        push_exp(1600, 2000, t + 5);
        wait_to(t + 6);

        // Per-channel pan: A left, B mute, C both
        mode = 2'd3;
        pan  = 6'b00_11_01;
        issue_now(t);
        push_exp(1600, 1200, t + 5);
        drain();
        check("overrun_min_spacing", int'(overrun), 0);

        // Overrun: second strobe mid-mix is ignored
        mode = 2'd0;
        set_ch(100, 200, 300);
        issue_now(t);
        push_exp(2400, 2400, t + 5);
        wait_to(t + 2);
        set_ch(4095, 4095, 4095);
        issue_now(t2);
        drain();
        check("overrun_set", int'(overrun), 1);
        wait_to(t2 + 6);

        // Mid-mix reset: no result, everything cleared
        set_ch(1000, 1000, 1000);
        issue_now(t);
        wait_to(t + 3);
        RESET = 1'b1;
        @(posedge clk_sys);
        #1;
        RESET = 1'b0;
        repeat (8) @(posedge clk_sys);
        #1;
        check("abort_out_l", int'(out_l), 0);
        check("abort_out_r", int'(out_r), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_overrun", int'(overrun), 0);

        // Low-pass step from 0 to full scale
        lpf_en = 1'b1;
        mode   = 2'd0;
        set_ch(4095, 4095, 4095);
        issue_now(t);
        push_exp(6142, 6142, t + 5);
        wait_to(t + 6);
        issue_now(t);
        push_exp(11516, 11516, t + 5);
        drain();
        check("hold_out_l", int'(out_l), 11516);

        repeat (4) @(posedge clk_sys);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
